// File: rtl/multi_chooser.sv
//==============================================================================
// multi_chooser -- N-way confidence-counter chooser for the branch predictor.
// Optional feature macro: MULTI_CHOOSER_GHR_HASH_EN (XOR history into index).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module multi_chooser #(
  parameter int INSTR_PER_FETCH = 2,
  parameter int NUM_PRED        = 3,
  parameter int ENTRIES         = 256,
  parameter int CTR_BITS        = 2,
  parameter int GHR_BITS        = 8,
  parameter int PC_BITS         = 39,
  parameter int ALIGN_BITS      = 1,
  localparam int IDX    = $clog2(ENTRIES),
  localparam int SEL_W  = $clog2(NUM_PRED),
  localparam int SLOT_W = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  output logic                                ready_o,
  input  logic                                lookup_valid_i,
  input  logic [PC_BITS-1:0]                  vpc_i,
  input  logic [INSTR_PER_FETCH*NUM_PRED-1:0] comp_taken_i,
  output logic                                pred_valid_o,
  output logic [INSTR_PER_FETCH*SEL_W-1:0]    sel_o,
  output logic [INSTR_PER_FETCH-1:0]          taken_o,
  output logic [IDX-1:0]                      index_o,
  input  logic                                update_valid_i,
  input  logic [IDX-1:0]                      update_index_i,
  input  logic [SLOT_W-1:0]                   update_slot_i,
  input  logic                                update_taken_i,
  input  logic [NUM_PRED-1:0]                 update_comp_taken_i
);

  localparam int SW = NUM_PRED * CTR_BITS;
  localparam int EW = INSTR_PER_FETCH * SW;
  localparam logic [CTR_BITS-1:0] C_CTR_INIT   = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] C_CTR_MAX    = '1;
  localparam logic [EW-1:0]       C_ENTRY_INIT = {(INSTR_PER_FETCH*NUM_PRED){C_CTR_INIT}};

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX-1:0]       r_ptr, w_ptr_nxt;
  logic [GHR_BITS-1:0]  r_ghr;
  logic [EW-1:0]        r_tab [ENTRIES];

  logic                              w_lk_acc;
  logic [IDX-1:0]                    w_lk_idx;
  logic [IDX-1:0]                    w_ghr_ext;
  logic [EW-1:0]                     w_lk_entry;
  logic [INSTR_PER_FETCH*SEL_W-1:0]  w_lk_sel;
  logic [CTR_BITS-1:0]               w_best;
  logic [SEL_W-1:0]                  w_bsel;
  logic                              r_pred_valid;
  logic [INSTR_PER_FETCH*SEL_W-1:0]  r_sel;
  logic [IDX-1:0]                    r_index;

  logic                 w_upd_acc;
  logic                 r_u1_valid;
  logic [IDX-1:0]       r_u1_idx;
  logic [SLOT_W-1:0]    r_u1_slot;
  logic                 r_u1_taken;
  logic [NUM_PRED-1:0]  r_u1_comp;
  logic [SW-1:0]        r_u1_ctr;
  logic                 w_u1_fwd;
  logic                 w_u2_we;
  logic [SW-1:0]        w_u2_new;
  logic [CTR_BITS-1:0]  w_cur;

  //--------------------------------------------------------------------------
  // Init sweep FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (flush_i) begin
      w_state_nxt = ST_INIT;
      w_ptr_nxt   = '0;
    end else if (r_state == ST_INIT) begin
      w_ptr_nxt = r_ptr + 1'b1;
      if (r_ptr == IDX'(ENTRIES-1)) w_state_nxt = ST_RUN;
    end
  end

  assign ready_o = (r_state == ST_RUN);

  //--------------------------------------------------------------------------
  // Table storage: init sweep owns the write port outside RUN
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (r_state == ST_INIT) begin
      r_tab[r_ptr] <= C_ENTRY_INIT;
    end else if (w_u2_we) begin
      r_tab[r_u1_idx][r_u1_slot*SW +: SW] <= w_u2_new;
    end
  end

  //--------------------------------------------------------------------------
  // Lookup
  //--------------------------------------------------------------------------
  always_comb begin
    w_ghr_ext = '0;
    w_ghr_ext[GHR_BITS-1:0] = r_ghr;
  end

`ifdef MULTI_CHOOSER_GHR_HASH_EN
  assign w_lk_idx = vpc_i[ALIGN_BITS +: IDX] ^ w_ghr_ext;
`else
  assign w_lk_idx = vpc_i[ALIGN_BITS +: IDX];
`endif

  assign w_lk_acc   = lookup_valid_i & ready_o & ~flush_i;
  assign w_lk_entry = r_tab[w_lk_idx];

  // Strict compare keeps ties on the lowest-numbered component
  always_comb begin
    w_lk_sel = '0;
    w_best   = '0;
    w_bsel   = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      w_best = w_lk_entry[s*SW +: CTR_BITS];
      w_bsel = '0;
      for (int c = 1; c < NUM_PRED; c++) begin
        if (w_lk_entry[s*SW + c*CTR_BITS +: CTR_BITS] > w_best) begin
          w_best = w_lk_entry[s*SW + c*CTR_BITS +: CTR_BITS];
          w_bsel = SEL_W'(c);
        end
      end
      w_lk_sel[s*SEL_W +: SEL_W] = w_bsel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pred_valid <= 1'b0;
      r_sel        <= '0;
      r_index      <= '0;
    end else begin
      r_pred_valid <= w_lk_acc;
      if (w_lk_acc) begin
        r_sel   <= w_lk_sel;
        r_index <= w_lk_idx;
      end
    end
  end

  assign pred_valid_o = r_pred_valid;
  assign sel_o        = r_sel;
  assign index_o      = r_index;

  always_comb begin
    taken_o = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      taken_o[s] = r_pred_valid & comp_taken_i[s*NUM_PRED + int'(r_sel[s*SEL_W +: SEL_W])];
    end
  end

  //--------------------------------------------------------------------------
  // Update pipeline: U1 captures counters, U2 computes and writes back
  //--------------------------------------------------------------------------
  assign w_upd_acc = update_valid_i & ready_o & ~flush_i;
  assign w_u2_we   = r_u1_valid & ready_o & ~flush_i & ~rst_i;
  assign w_u1_fwd  = w_u2_we && (r_u1_idx == update_index_i) && (r_u1_slot == update_slot_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_u1_valid <= 1'b0;
      r_ghr      <= '0;
    end else begin
      r_u1_valid <= w_upd_acc;
      if (w_upd_acc) r_ghr <= {r_ghr[GHR_BITS-2:0], update_taken_i};
    end
  end

  // Forwarding makes back-to-back updates to one slot compose sequentially
  always_ff @(posedge clk_i) begin
    if (w_upd_acc) begin
      r_u1_idx   <= update_index_i;
      r_u1_slot  <= update_slot_i;
      r_u1_taken <= update_taken_i;
      r_u1_comp  <= update_comp_taken_i;
      r_u1_ctr   <= w_u1_fwd ? w_u2_new : r_tab[update_index_i][update_slot_i*SW +: SW];
    end
  end

  always_comb begin
    w_u2_new = r_u1_ctr;
    w_cur    = '0;
    if ((|r_u1_comp) && !(&r_u1_comp)) begin
      for (int c = 0; c < NUM_PRED; c++) begin
        w_cur = r_u1_ctr[c*CTR_BITS +: CTR_BITS];
        if (r_u1_comp[c] == r_u1_taken) begin
          if (w_cur != C_CTR_MAX) w_cur = w_cur + 1'b1;
        end else if (w_cur != '0) begin
          w_cur = w_cur - 1'b1;
        end
        w_u2_new[c*CTR_BITS +: CTR_BITS] = w_cur;
      end
    end
  end

endmodule

`default_nettype wire
